// File: rtl/stack_ctrl8.sv
// -----------------------------------------------------------------------------
// stack_ctrl8 -- LIFO stack controller in front of an external 8-entry ram8.
//
// A push is latched in IDLE and written to the RAM during one WRITE cycle.
// A pop reads the RAM during one READ cycle, and the word is captured into dout.
// A request is accepted only while ready=1, which means the FSM is in IDLE.
//
// Ports
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high reset (takes priority over requests)
//   push, pop   requests, accepted only when ready=1 (push wins if both high)
//   din         word to push, sampled on the accepting edge
//   ready       high in IDLE only
//   dout        last popped word, held until the next pop completes
//   dout_valid  one-cycle strobe marking a new dout
//   count       entries stored, 0..2**AW
//   full/empty  count==2**AW / count==0
//   overflow    sticky: push attempted while full
//   underflow   sticky: pop attempted while empty
//   ram_adr     RAM address (0 while idle)
//   ram_data    RAM write data (always the latched push word)
//   ram_load    RAM write enable, high for the WRITE cycle only
//   ram_out     RAM read data, combinational from ram_adr
// -----------------------------------------------------------------------------
module stack_ctrl8 #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow,
  output logic [AW-1:0]    ram_adr,
  output logic [WIDTH-1:0] ram_data,
  output logic             ram_load,
  input  logic [WIDTH-1:0] ram_out
);

  localparam int          DEPTH     = 2 ** AW;
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];
  localparam logic [AW:0] ONE       = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [AW:0]      count_dec;

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign ram_data  = data_q;
  // The top entry sits one below count; the pop path is taken only when count>0.
  assign count_dec = count - ONE;

  // The RAM-side outputs and ready are registered. They are loaded at the
  // accepting edge, so they are valid for exactly the WRITE/READ cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      data_q     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      ready      <= 1'b1;
      ram_load   <= 1'b0;
      ram_adr    <= '0;
    end else begin
      // NOTE: every register here uses <=, so all branches read the pre-edge
      // values of count/state; a blocking '=' would let a later line see a
      // half-updated count within the same edge.
      dout_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (push) begin
            if (!full) begin
              data_q   <= din;
              ram_adr  <= count[AW-1:0];
              ram_load <= 1'b1;
              ready    <= 1'b0;
              state    <= WRITE;
            end else begin
              overflow <= 1'b1;
            end
          end else if (pop) begin
            if (!empty) begin
              ram_adr <= count_dec[AW-1:0];
              ready   <= 1'b0;
              state   <= READ;
            end else begin
              underflow <= 1'b1;
            end
          end
        end

        WRITE: begin
          count    <= count + ONE;
          ram_load <= 1'b0;
          ram_adr  <= '0;
          ready    <= 1'b1;
          state    <= IDLE;
        end

        READ: begin
          dout       <= ram_out;
          dout_valid <= 1'b1;
          count      <= count_dec;
          ram_adr    <= '0;
          ready      <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          ram_load <= 1'b0;
          ram_adr  <= '0;
          ready    <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl8.sv
// -----------------------------------------------------------------------------
// tb_stack_ctrl8 -- scoreboard bench for stack_ctrl8.
// Stimulus pushes expected RAM writes and popped words into queues; a monitor
// on the falling edge pops and compares whenever ram_load or dout_valid is high.
// A behavioural ram8 (combinational read, write on clk edge) sits on the RAM port.
// -----------------------------------------------------------------------------
module tb_stack_ctrl8;

  localparam int WIDTH = 16;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic             ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;
  logic [AW-1:0]    ram_adr;
  logic [WIDTH-1:0] ram_data;
  logic             ram_load;
  logic [WIDTH-1:0] ram_out;

  stack_ctrl8 #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .din        (din),
    .ready      (ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .underflow  (underflow),
    .ram_adr    (ram_adr),
    .ram_data   (ram_data),
    .ram_load   (ram_load),
    .ram_out    (ram_out)
  );

  always #5 clk = ~clk;

  // Behavioural ram8.
  logic [WIDTH-1:0] mem [8];
  always @(posedge clk) if (ram_load === 1'b1) mem[ram_adr] <= ram_data;
  assign ram_out = mem[ram_adr];

  // Scoreboard.
  typedef struct {
    logic [AW-1:0]    adr;
    logic [WIDTH-1:0] data;
  } wr_t;

  wr_t              exp_wr[$];
  logic [WIDTH-1:0] exp_rd[$];
  int checks = 0;
  int errors = 0;

  // Reference model state.
  int               count_m;
  bit               ovf_m;
  bit               unf_m;
  logic [WIDTH-1:0] last_dout_m;
  logic [WIDTH-1:0] stk[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares RAM writes and popped words against the queues.
  always @(negedge clk) begin
    if (ram_load === 1'b1) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_ram_load", 32'(ram_adr), 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        check("ram_adr", 32'(ram_adr), 32'(w.adr));
        check("ram_data", 32'(ram_data), 32'(w.data));
      end
    end
    if (dout_valid === 1'b1) begin
      if (exp_rd.size() == 0) begin
        check("unexpected_dout_valid", 32'(dout), 32'hFFFF_FFFF);
      end else begin
        check("dout", 32'(dout), 32'(exp_rd.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, ":count"},     32'(count),     32'(count_m));
    check({tag, ":full"},      32'(full),      32'(count_m == 8));
    check({tag, ":empty"},     32'(empty),     32'(count_m == 0));
    check({tag, ":overflow"},  32'(overflow),  32'(ovf_m));
    check({tag, ":underflow"}, 32'(underflow), 32'(unf_m));
    check({tag, ":ready"},     32'(ready),     32'd1);
    check({tag, ":ram_load"},  32'(ram_load),  32'd0);
    check({tag, ":ram_adr"},   32'(ram_adr),   32'd0);
    check({tag, ":dout_hold"}, 32'(dout),      32'(last_dout_m));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    push  = 1'b0;
    pop   = 1'b0;
    din   = '0;
    tick();
    reset       = 1'b0;
    count_m     = 0;
    ovf_m       = 1'b0;
    unf_m       = 1'b0;
    last_dout_m = '0;
    stk.delete();
  endtask

  task automatic push_op(input logic [WIDTH-1:0] d, input logic with_pop);
    bit acc;
    acc  = (count_m < 8);
    push = 1'b1;
    pop  = with_pop;
    din  = d;
    if (acc) begin
      exp_wr.push_back('{adr: 3'(count_m), data: d});
      stk.push_back(d);
    end else begin
      ovf_m = 1'b1;
    end
    tick();
    push = 1'b0;
    pop  = 1'b0;
    din  = '0;
    if (acc) begin
      check("push_busy_ready", 32'(ready), 32'd0);
      tick();
      count_m++;
    end
    check_status("push");
  endtask

  task automatic pop_op();
    bit acc;
    acc = (count_m > 0);
    pop = 1'b1;
    if (acc) begin
      last_dout_m = stk.pop_back();
      exp_rd.push_back(last_dout_m);
    end else begin
      unf_m = 1'b1;
    end
    tick();
    pop = 1'b0;
    if (acc) begin
      check("pop_busy_ready", 32'(ready), 32'd0);
      tick();
      count_m--;
    end
    check_status("pop");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    push  = 1'b0;
    pop   = 1'b0;
    din   = '0;
    tick();
    do_reset();

    // Reset state.
    check_status("reset");
    check("reset:ram_data", 32'(ram_data), 32'd0);
    check("reset:dout_valid", 32'(dout_valid), 32'd0);

    // Pop while empty: underflow, dout stays 0, no strobe.
    pop_op();

    // Two pushes then two pops: LIFO order.
    push_op(16'h1234, 1'b0);
    push_op(16'h5678, 1'b0);
    check("mem0", 32'(mem[0]), 32'h1234);
    check("mem1", 32'(mem[1]), 32'h5678);
    pop_op();
    pop_op();

    // Push and pop together behaves as a push.
    push_op(16'h4242, 1'b1);
    pop_op();

    // Reset clears sticky flags.
    do_reset();
    check_status("reset2");

    // Fill, overflow on the ninth push, then pop the eighth word.
    for (int i = 0; i < 8; i++) push_op(16'hA000 + 16'(i), 1'b0);
    push_op(16'hBEEF, 1'b0);
    pop_op();

    // Push held high: accept every other edge until full, then overflow.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      push = 1'b1;
      din  = 16'hC000 + 16'(i);
      if ((i % 2 == 0) && (i < 16)) begin
        exp_wr.push_back('{adr: 3'(i / 2), data: 16'hC000 + 16'(i)});
        stk.push_back(16'hC000 + 16'(i));
      end
      tick();
      check("held:count", 32'(count), 32'(((i + 1) / 2 > 8) ? 8 : (i + 1) / 2));
      check("held:ready", 32'(ready), 32'((i % 2 == 1) || (i >= 15)));
    end
    push    = 1'b0;
    din     = '0;
    count_m = 8;
    ovf_m   = 1'b1;
    check_status("held");
    pop_op();

    // Reset during WRITE aborts the push.
    do_reset();
    push = 1'b1;
    din  = 16'h7777;
    exp_wr.push_back('{adr: 3'd0, data: 16'h7777});
    tick();
    push  = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_status("abort_write");

    // Reset during READ: no strobe, count back to 0.
    push_op(16'h1111, 1'b0);
    pop = 1'b1;
    tick();
    pop   = 1'b0;
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    count_m     = 0;
    last_dout_m = '0;
    stk.delete();
    tick();
    check_status("abort_read");

    check("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
    check("exp_rd_drained", 32'(exp_rd.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_ctrl8.md
STACK_CTRL8 -- requirements
Module: stack_ctrl8

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data word width (matches the ram8 word).
REQ-002 The block SHALL have parameter AW, default 3, RAM address width; depth is 2**AW = 8.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 push  input  1  push request, accepted only when ready=1.
REQ-006 pop  input  1  pop request, accepted only when ready=1.
REQ-007 din  input  WIDTH  word to push, sampled on the accepting edge.
REQ-008 ready  output  1  high when a new push or pop can be accepted.
REQ-009 dout  output  WIDTH  last popped word, held until the next pop completes.
REQ-010 dout_valid  output  1  one-cycle strobe marking a new dout.
REQ-011 count  output  AW+1  entries currently stored, 0..8.
REQ-012 full / empty  output  1 each  count==8 / count==0.
REQ-013 overflow / underflow  output  1 each  sticky error flags.
REQ-014 ram_adr  output  AW  address to ram8.
REQ-015 ram_data  output  WIDTH  write data to ram8.
REQ-016 ram_load  output  1  write enable to ram8, which writes on the clk edge while high.
REQ-017 ram_out  input  WIDTH  ram8 read data, combinational from ram_adr.

Function
REQ-018 FSM states SHALL be IDLE, WRITE and READ; ready SHALL be 1 only in IDLE.
REQ-019 IDLE with push=1, count<8: latch din into the data register, go to WRITE.
REQ-020 WRITE (exactly one cycle): ram_adr=count[AW-1:0], ram_data=latched word, ram_load=1; at the closing edge count+1, go to IDLE.
REQ-021 IDLE with pop=1 (push=0), count>0: go to READ.
REQ-022 READ (exactly one cycle): ram_adr=count-1, ram_load=0; at the closing edge dout<=ram_out, dout_valid<=1, count-1, go to IDLE.
REQ-023 Latency: accept at edge E0, operation completes at E1; the next request can be accepted at E2; dout_valid is high during the cycle E1..E2 only.
REQ-024 In IDLE, ram_load SHALL be 0 and ram_adr 0; ram_data SHALL always equal the latched data register.
REQ-025 push and pop both high in IDLE: push wins; pop is ignored and no flag is set.
REQ-026 push while full: the request is rejected, the FSM stays in IDLE, count is unchanged, overflow<=1, and no RAM write occurs.
REQ-027 pop while empty (push=0): the request is rejected, underflow<=1, and dout and dout_valid are unchanged/low.
REQ-028 Requests while ready=0 SHALL be ignored without setting any flag.
REQ-029 count SHALL never exceed 8 or go below 0; the RAM address is 3 bits and never wraps, because of REQ-026 and REQ-027.
REQ-030 overflow and underflow SHALL clear only on reset.
REQ-031 dout SHALL change only at the completion of a READ.

Reset
REQ-032 When reset=1 at a clk edge, the block SHALL force state=IDLE, count=0, and set dout, the data register, overflow, underflow and dout_valid to 0; reset takes priority over all requests.
REQ-033 After reset, outputs SHALL read: ready=1, empty=1, full=0, ram_load=0, ram_adr=0, ram_data=0.
REQ-034 Reset asserted during WRITE or READ SHALL abort the operation: ram_load=0 from the reset edge onward, no count change, and no dout_valid.

Verification
REQ-035 Push 0x1234, then 0x5678 -> ram_load pulses at adr 0, then adr 1; count=2; ram8 holds both words.
REQ-036 Pop twice after REQ-035 -> dout=0x5678, then 0x1234, each with a one-cycle dout_valid; count=0, empty=1.
REQ-037 Push 8 words, then a 9th push -> 9th rejected, overflow=1, count=8, no ram_load; a pop then returns word 8.
REQ-038 Pop at reset -> underflow=1, dout=0, dout_valid never high; push and pop held together -> behaves as a push.
REQ-039 Assert reset in the WRITE cycle of a push -> count=0, ram_load low after the edge, ready=1.
REQ-040 Hold push high continuously -> one accept every 2 cycles, count increments on alternate edges until full.
